// File: rtl/mul_seq_16_if.sv
// Request/result bundle for the sequential 16-bit multiplier.
// Latency: wiring only, no registers.
// Backpressure: none; requests are dropped while busy is high.
//
// Signals:
//   start   - request, honoured only while the multiplier is idle
//   a, b    - multiplicand / multiplier, captured when start is accepted
//   busy    - high while an operation occupies the multiplier (RUN and DONE)
//   done    - one-cycle pulse, product is valid
//   product - low 16 bits of a*b, held until the next operation completes
interface mul_seq_16_if;
    logic        start;
    logic [15:0] a;
    logic [15:0] b;
    logic        busy;
    logic        done;
    logic [15:0] product;

    modport master (
        output start, a, b,
        input  busy, done, product
    );

    modport slave (
        input  start, a, b,
        output busy, done, product
    );
endinterface

// File: rtl/mul_seq_16.sv
// Shift-and-add 16x16 multiplier (low 16 bits) built on one shared 16-bit adder.
// Latency: start accepted at E0, done pulses between E16 and E17, idle again after E17.
// Backpressure: none; start is ignored (not queued) while busy, including the DONE cycle.
//
// Ports:
//   clk   - rising-edge clock
//   reset - synchronous, active-high; aborts any operation and clears product
//   bus   - mul_seq_16_if slave: start/a/b in, busy/done/product out

// Plain 16-bit adder; the carry-out is dropped so sums wrap modulo 2^16.
module my_adder_16 (
    input  logic [15:0] x,
    input  logic [15:0] y,
    output logic [15:0] sum
);
    assign sum = x + y;
endmodule

module mul_seq_16 #(
    parameter int WIDTH = 16,
    parameter int ITERS = 16
) (
    input  logic         clk,
    input  logic         reset,
    mul_seq_16_if.slave  bus
);
    localparam int CNT_W = 5;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t             state;
    state_t             state_nxt;
    logic [WIDTH-1:0]   mcand;
    logic [WIDTH-1:0]   mplier;
    logic [WIDTH-1:0]   acc;
    logic [WIDTH-1:0]   product_q;
    logic [CNT_W-1:0]   count;
    logic [WIDTH-1:0]   addend;
    logic [WIDTH-1:0]   sum;
    logic               last_iter;
    logic               accept;
    logic               busy_c;
    logic               done_c;

    // Partial product for this iteration: the current shifted multiplicand
    // when the multiplier's low bit is set, otherwise nothing.
    assign addend    = mplier[0] ? mcand : '0;
    assign last_iter = (count == CNT_W'(ITERS - 1));
    assign accept    = (state == IDLE) && bus.start;

    my_adder_16 u_adder (
        .x   (acc),
        .y   (addend),
        .sum (sum)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        busy_c    = 1'b0;
        done_c    = 1'b0;
        case (state)
            IDLE: begin
                if (bus.start) begin
                    state_nxt = RUN;
                end
            end
            RUN: begin
                busy_c = 1'b1;
                if (last_iter) begin
                    state_nxt = DONE;
                end
            end
            DONE: begin
                busy_c    = 1'b1;
                done_c    = 1'b1;
                state_nxt = IDLE;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            mcand     <= '0;
            mplier    <= '0;
            acc       <= '0;
            count     <= '0;
            product_q <= '0;
        end else if (accept) begin
            mcand  <= bus.a;
            mplier <= bus.b;
            acc    <= '0;
            count  <= '0;
        end else if (state == RUN) begin
            acc    <= sum;
            mcand  <= mcand << 1;
            mplier <= mplier >> 1;
            count  <= count + CNT_W'(1);
            // The final add lands straight in product; acc's copy is dead.
            if (last_iter) begin
                product_q <= sum;
            end
        end
    end

    assign bus.busy    = busy_c;
    assign bus.done    = done_c;
    assign bus.product = product_q;
endmodule

// File: tb/tb_mul_seq_16.sv
// Self-checking bench for mul_seq_16: directed corner cases plus a random sweep
// with back-to-back restarts, compared against plain (a*b) mod 2^16 arithmetic
// and the fixed 17-cycle occupancy.
module tb_mul_seq_16;
    logic clk = 1'b0;
    logic reset;
    int   n_chk  = 0;
    int   n_pass = 0;
    logic [15:0] last_prod;

    mul_seq_16_if bus ();

    mul_seq_16 dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
    endtask

    function automatic logic [15:0] ref_mul(input logic [15:0] x, input logic [15:0] y);
        longint p;
        p = longint'(x) * longint'(y);
        return p[15:0];
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One full operation from the idle state. pulse_at (1..15) injects a
    // stray start with a=b=2 sampled at that RUN edge; pulse_done holds start
    // during the DONE cycle. Neither may alter the result or occupancy.
    task automatic do_op(input logic [15:0] x, input logic [15:0] y,
                         input int pulse_at, input bit pulse_done, input string tag);
        logic [15:0] exp;
        bit bad;
        exp = ref_mul(x, y);
        bad = 1'b0;
        bus.start = 1'b1; bus.a = x; bus.b = y;
        tick();                                  // E0
        bus.start = 1'b0; bus.a = 16'($urandom); bus.b = 16'($urandom);
        check({tag, "_busy_e0"}, 32'(bus.busy), 32'd1);
        for (int k = 1; k <= 16; k++) begin
            bus.start = (k == pulse_at);
            if (k == pulse_at) begin bus.a = 16'd2; bus.b = 16'd2; end
            tick();                              // E_k
            if (k < 16 && (bus.busy !== 1'b1 || bus.done !== 1'b0)) bad = 1'b1;
            if (k == 8) check({tag, "_prod_hold"}, 32'(bus.product), 32'(last_prod));
        end
        check({tag, "_run_flags"}, 32'(bad), 32'd0);
        check({tag, "_done"}, {30'd0, bus.busy, bus.done}, 32'd3);
        check({tag, "_product"}, 32'(bus.product), 32'(exp));
        bus.start = pulse_done; bus.a = 16'd2; bus.b = 16'd2;
        tick();                                  // E17
        bus.start = 1'b0;
        check({tag, "_idle_e17"}, {30'd0, bus.busy, bus.done}, 32'd0);
        last_prod = exp;
    endtask

    initial begin
        logic [15:0] x, y;
        bit bad;
        reset = 1'b1; bus.start = 1'b0; bus.a = '0; bus.b = '0;
        last_prod = 16'd0;
        repeat (3) tick();
        check("reset_flags", {30'd0, bus.busy, bus.done}, 32'd0);
        check("reset_product", 32'(bus.product), 32'd0);
        reset = 1'b0;
        tick();

        do_op(16'd3, 16'd5, 0, 1'b0, "3x5");
        do_op(16'h1234, 16'h0000, 0, 1'b0, "b_zero");
        do_op(16'h0000, 16'hFFFF, 0, 1'b0, "a_zero");
        do_op(16'hFFFF, 16'hFFFF, 0, 1'b0, "ffff_sq");
        do_op(16'h0100, 16'h0100, 0, 1'b0, "wrap");
        do_op(16'd7, 16'd6, 5, 1'b1, "7x6_ignored_starts");
        check("7x6_not_queued", 32'(bus.busy), 32'd0);
        do_op(16'd2, 16'd2, 0, 1'b0, "2x2_restart");

        // Reset sampled at E8 of an in-flight operation.
        bus.start = 1'b1; bus.a = 16'd100; bus.b = 16'd100;
        tick();
        bus.start = 1'b0;
        repeat (7) tick();
        reset = 1'b1;
        tick();                                  // E8
        reset = 1'b0;
        check("abort_flags", {30'd0, bus.busy, bus.done}, 32'd0);
        check("abort_product", 32'(bus.product), 32'd0);
        bad = 1'b0;
        repeat (20) begin
            tick();
            if (bus.done !== 1'b0 || bus.busy !== 1'b0) bad = 1'b1;
        end
        check("abort_no_done", 32'(bad), 32'd0);
        last_prod = 16'd0;
        do_op(16'd100, 16'd100, 0, 1'b0, "100x100");

        // reset and start on the same edge: start must be dropped.
        reset = 1'b1; bus.start = 1'b1; bus.a = 16'd5; bus.b = 16'd5;
        tick();
        reset = 1'b0; bus.start = 1'b0;
        tick();
        check("rst_start_busy", 32'(bus.busy), 32'd0);
        check("rst_start_product", 32'(bus.product), 32'd0);
        last_prod = 16'd0;

        for (int i = 0; i < 1000; i++) begin
            x = 16'($urandom);
            y = 16'($urandom);
            if (i % 50 == 0) x = 16'hFFFF;
            if (i % 70 == 0) y = 16'h0000;
            do_op(x, y, (i % 7 == 0) ? int'($urandom_range(15, 1)) : 0,
                  (i % 5 == 0), "rand");
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
